uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 144 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small valid/ready FIFO feeding a baud-timed
// serializer that drains it back-to-back with no idle gap between frames.
module uart_tx_fifo #(
  parameter int unsigned CLKRATE  = 1_789_773,
  parameter int unsigned BAUDRATE = 9600,
  parameter int unsigned DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned BAUD_DIV = CLKRATE / BAUDRATE;
  localparam int unsigned BW       = $clog2(BAUD_DIV + 1);
  localparam int unsigned PW       = $clog2(DEPTH);
  localparam int unsigned CW       = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            tx_ready_q, tx_ready_d;
  logic            busy_q, busy_d;
  logic [7:0]      mem_q [DEPTH];

  logic            push_c;
  logic            pop_c;
  logic            cell_end_c;
  logic            fifo_empty_c;

  assign push_c       = tx_valid && tx_ready_q;
  assign cell_end_c   = (baud_q == BW'(BAUD_DIV - 1));
  assign fifo_empty_c = (count_q == '0);

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;

  // State register and all datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_c) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  // Next-state logic; pops happen on leaving IDLE or at the end of STOP
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_c) begin
          pop_c   = 1'b1;
          state_d = S_START;
        end
      end
      S_START: if (cell_end_c) state_d = S_DATA;
      S_DATA:  if (cell_end_c && bit_q == 3'd7) state_d = S_STOP;
      S_STOP: begin
        if (cell_end_c) begin
          if (!fifo_empty_c) begin
            pop_c   = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic; tx is derived from the current state and registered
  always_comb begin
    baud_d     = baud_q + BW'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = 1'b1;
    wr_ptr_d   = wr_ptr_q + PW'(push_c);
    rd_ptr_d   = rd_ptr_q + PW'(pop_c);
    count_d    = count_q + CW'(push_c) - CW'(pop_c);

    if (pop_c || cell_end_c || state_q == S_IDLE) baud_d = '0;
    if (pop_c) shift_d = mem_q[rd_ptr_q];

    case (state_q)
      S_START: begin
        tx_d = 1'b0;
        if (cell_end_c) bit_d = '0;
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (cell_end_c) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
        end
      end
      default: tx_d = 1'b1;
    endcase

    tx_ready_d = (count_d != CW'(DEPTH));
    busy_d     = (state_d != S_IDLE) || (count_d != '0);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: line timing, FIFO full boundary, reset abort.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int BAUD_DIV = 1_789_773 / 9600;
  localparam int FRAME    = 10 * BAUD_DIV;
  localparam int PERIOD   = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] rx_q[$];
  time        rx_t[$];

  uart_tx_fifo dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .busy     (busy)
  );

  always #(PERIOD/2) clk = ~clk;
  always @(posedge clk) cyc++;

  // Line decoder: samples mid-cell and collects bytes with their start times
  always begin : monitor
    logic [7:0] b;
    time        st;
    @(negedge tx);
    st = $time;
    repeat (BAUD_DIV/2) @(posedge clk);
    #1;
    n_cmp++;
    if (tx !== 1'b0) begin n_err++; $display("FAIL mon_start: tx=%b need 0", tx); end
    for (int i = 0; i < 8; i++) begin
      repeat (BAUD_DIV) @(posedge clk);
      #1;
      b[i] = tx;
    end
    repeat (BAUD_DIV) @(posedge clk);
    #1;
    n_cmp++;
    if (tx !== 1'b1) begin n_err++; $display("FAIL mon_stop: tx=%b need 1", tx); end
    rx_q.push_back(b);
    rx_t.push_back(st);
  end

  // Offer one byte and return #1 after the edge that accepts it
  task automatic send(input logic [7:0] d);
    logic rdy;
    bit   done = 1'b0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int n = 0; n < 5000 && !done; n++) begin
      rdy = tx_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: byte %h never accepted", d);
    end
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy !== 1'b0 && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy !== 1'b0) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles", busy, n);
    end
    repeat (100) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (tx !== 1'b1)   begin n_err++; $display("FAIL rst_tx: got %b need 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b need 0", busy); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b need 1", tx_ready); end
    n_cmp++; if (tx !== 1'b1)       begin n_err++; $display("FAIL rst_tx_rel: got %b need 1", tx); end
  endtask

  task automatic test_single;
    logic [9:0] fr;
    int bad = 0;
    logic b_hi, b_lo;
    rx_q.delete(); rx_t.delete();
    fr = {1'b1, 8'h55, 1'b0};
    send(8'h55);
    tx_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_rise: got %b need 1", busy); end
    n_cmp++; if (tx !== 1'b1)   begin n_err++; $display("FAIL single_tx_k: got %b need 1", tx); end
    @(posedge clk); #1;
    n_cmp++; if (tx !== 1'b1)   begin n_err++; $display("FAIL single_tx_k1: got %b need 1", tx); end
    @(posedge clk); #1;
    n_cmp++; if (tx !== 1'b0)   begin n_err++; $display("FAIL single_tx_k2: got %b need 0", tx); end
    b_hi = 1'b0; b_lo = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (tx !== fr[i / BAUD_DIV]) bad++;
      if (i == FRAME - 2) b_hi = busy;
      if (i == FRAME - 1) b_lo = busy;
    end
    n_cmp++; if (bad != 0)     begin n_err++; $display("FAIL single_wave: %0d bad cycles need 0", bad); end
    n_cmp++; if (b_hi !== 1'b1) begin n_err++; $display("FAIL single_busy_late: got %b need 1", b_hi); end
    n_cmp++; if (b_lo !== 1'b0) begin n_err++; $display("FAIL single_busy_fall: got %b need 0", b_lo); end
    wait_idle(4000);
    n_cmp++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      n_err++; $display("FAIL single_rx: size=%0d first=%h need 1/55", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00);
    end
  endtask

  task automatic test_back_to_back;
    int hi = 0;
    rx_q.delete(); rx_t.delete();
    send(8'hA5);
    send(8'h3C);
    tx_valid = 1'b0;
    while (busy === 1'b1 && hi < 10000) begin
      hi++;
      @(posedge clk); #1;
    end
    n_cmp++; if (hi != 2*FRAME) begin n_err++; $display("FAIL b2b_busy: high %0d cycles need %0d", hi, 2*FRAME); end
    wait_idle(100);
    n_cmp++;
    if (rx_q.size() != 2) begin
      n_err++; $display("FAIL b2b_count: got %0d need 2", rx_q.size());
    end else begin
      n_cmp++; if (rx_q[0] !== 8'hA5) begin n_err++; $display("FAIL b2b_byte0: got %h need a5", rx_q[0]); end
      n_cmp++; if (rx_q[1] !== 8'h3C) begin n_err++; $display("FAIL b2b_byte1: got %h need 3c", rx_q[1]); end
      n_cmp++;
      if (rx_t[1] - rx_t[0] != FRAME * PERIOD) begin
        n_err++; $display("FAIL b2b_gap: got %0t need %0d", rx_t[1] - rx_t[0], FRAME * PERIOD);
      end
    end
  endtask

  task automatic test_full;
    logic rdy, rdy5, full_seen;
    int acc = 0, acc5 = -1, k = 0, ret = 0;
    rx_q.delete(); rx_t.delete();
    full_seen = 1'b0; rdy5 = 1'b1;
    tx_data = 8'h01; tx_valid = 1'b1;
    for (int c = 1; c < 40000 && acc < 8; c++) begin
      rdy = tx_ready;
      @(posedge clk); #1;
      if (rdy) begin
        acc++;
        if (acc == 1) k = cyc;
        tx_data = tx_data + 8'd1;
        if (acc == 8) tx_valid = 1'b0;
      end
      if (c == 5) begin acc5 = acc; rdy5 = tx_ready; end
      if (tx_ready === 1'b0) full_seen = 1'b1;
      if (full_seen && tx_ready === 1'b1 && ret == 0) ret = cyc;
    end
    tx_valid = 1'b0;
    n_cmp++; if (acc5 != 5)     begin n_err++; $display("FAIL full_accepted: got %0d need 5", acc5); end
    n_cmp++; if (rdy5 !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b need 0", rdy5); end
    n_cmp++; if (ret != k + FRAME + 1) begin n_err++; $display("FAIL full_ready_ret: cycle %0d need %0d", ret - k, FRAME + 1); end
    n_cmp++; if (acc != 8)      begin n_err++; $display("FAIL full_total: got %0d need 8", acc); end
    wait_idle(20000);
    n_cmp++;
    if (rx_q.size() != 8) begin
      n_err++; $display("FAIL full_rx_count: got %0d need 8", rx_q.size());
    end else begin
      int bad = 0;
      for (int i = 0; i < 8; i++) if (rx_q[i] !== 8'(i + 1)) bad++;
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL full_rx_order: %0d wrong bytes need 0", bad); end
    end
  endtask

  task automatic test_hold;
    logic [7:0] arr [6];
    logic rdy;
    int idx = 0, hold = 0;
    arr = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h99};
    rx_q.delete(); rx_t.delete();
    tx_data = arr[0]; tx_valid = 1'b1;
    for (int c = 0; c < 20000 && idx < 6; c++) begin
      rdy = tx_ready;
      if (!rdy && idx == 5) hold++;
      @(posedge clk); #1;
      if (rdy) begin
        idx++;
        if (idx < 6) tx_data = arr[idx];
        else tx_valid = 1'b0;
      end
    end
    tx_valid = 1'b0;
    n_cmp++; if (hold != FRAME - 3) begin n_err++; $display("FAIL hold_cycles: got %0d need %0d", hold, FRAME - 3); end
    wait_idle(20000);
    n_cmp++;
    if (rx_q.size() != 6) begin
      n_err++; $display("FAIL hold_rx_count: got %0d need 6", rx_q.size());
    end else begin
      int bad = 0;
      for (int i = 0; i < 6; i++) if (rx_q[i] !== arr[i]) bad++;
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL hold_rx_order: %0d wrong bytes need 0", bad); end
    end
  endtask

  task automatic test_reset_mid;
    int k, bad = 0, n = 0;
    send(8'hF0);
    k = cyc;
    send(8'h01); send(8'h02); send(8'h03);
    tx_valid = 1'b0;
    while (cyc < k + 2 + 4*BAUD_DIV + 90 && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    n_cmp++; if (tx !== 1'b0)   begin n_err++; $display("FAIL midrst_bit3: got %b need 0", tx); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_pre: got %b need 1", busy); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1)   begin n_err++; $display("FAIL midrst_tx: got %b need 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b need 0", busy); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b need 1", tx_ready); end
    for (int i = 0; i < 3000; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL midrst_quiet: %0d active cycles need 0", bad); end
    rx_q.delete(); rx_t.delete();
  endtask

  task automatic test_loopback;
    logic [7:0] exp_q[$];
    logic [7:0] d;
    rx_q.delete(); rx_t.delete();
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(d);
      send(d);
    end
    tx_valid = 1'b0;
    wait_idle(20000);
    n_cmp++;
    if (rx_q.size() != 6) begin
      n_err++; $display("FAIL loop_count: got %0d need 6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL loop_byte%0d: got %h need %h", i, rx_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_hold();
    test_reset_mid();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
